rx_block_buffer: RTL and testbench

Receive-side buffer of the AES communication module. Packs the byte stream from the UART receiver into 128-bit plaintext blocks and queues complete blocks in a small FIFO. The AES control block consumes them through the `pt`/`rx_empty`/`rx_read` interface. This block is the responder on that interface; the control block is the reader.

---
 rtl/rx_block_buffer_pkg.sv | 20 ++
 rtl/rx_block_buffer_fifo.sv | 72 +++++++
 rtl/rx_block_buffer.sv | 82 ++++++++
 tb/tb_rx_block_buffer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/rx_block_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rx_block_buffer_pkg
// Description : Shared block/byte geometry for the AES communication buffers.
// Revision    : 1.0 - initial release
// ============================================================================
package rx_block_buffer_pkg;

   localparam int c_BLOCK_W         = 128;
   localparam int c_BYTE_W          = 8;
   localparam int c_BYTES_PER_BLOCK = 16;

   // Bytes 1..15 are held here; byte 16 is concatenated directly on completion.
   localparam int c_SHIFT_W = c_BLOCK_W - c_BYTE_W;

   localparam int c_IDX_W = $clog2(c_BYTES_PER_BLOCK);
   localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(c_BYTES_PER_BLOCK - 1);

endpackage : rx_block_buffer_pkg
`default_nettype wire

// File: rtl/rx_block_buffer_fifo.sv
`default_nettype none
// ============================================================================
// Module      : block_fifo
// Description : Show-ahead block FIFO with occupancy count. A push while full
//               is accepted only when a valid pop happens on the same edge.
// Revision    : 1.0 - initial release
// ============================================================================
module block_fifo #(
   parameter int WIDTH = 128,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_data,
   input  logic                     i_pop,
   output logic                     o_accept,
   output logic [WIDTH-1:0]         o_head,
   output logic                     o_empty,
   output logic                     o_full,
   output logic [$clog2(DEPTH):0]   o_level
);

   localparam int c_AW = $clog2(DEPTH);
   localparam int c_LW = c_AW + 1;
   localparam logic [c_LW-1:0] c_FULL_LVL = c_LW'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [c_AW-1:0]  r_wr_ptr;
   logic [c_AW-1:0]  r_rd_ptr;
   logic [c_LW-1:0]  r_level;

   logic w_pop_ok;
   logic w_push_ok;

   // Flags come only from the registered level, so rx_read never reaches them combinationally.
   assign o_empty  = (r_level == '0);
   assign o_full   = (r_level == c_FULL_LVL);
   assign w_pop_ok = i_pop && !o_empty;
   // Space exists if not full, or if the head leaves on this same edge.
   assign o_accept  = !o_full || w_pop_ok;
   assign w_push_ok = i_push && o_accept;

   assign o_level = r_level;
   assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

   // Storage write; writes land at wr_ptr so the head entry is never disturbed.
   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // Pointer and occupancy update; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_AW'(1);
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_level <= r_level + c_LW'(1);
            2'b01:   r_level <= r_level - c_LW'(1);
            default: r_level <= r_level;
         endcase
      end
   end

endmodule : block_fifo
`default_nettype wire

// File: rtl/rx_block_buffer.sv
`default_nettype none
// ============================================================================
// Module      : rx_block_buffer
// Description : Packs UART bytes into 128-bit blocks (first byte in the MSBs)
//               and queues them for the AES control block.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_block_buffer
   import rx_block_buffer_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [c_BYTE_W-1:0]     rx_data,
   input  logic                    rx_valid,
   input  logic                    byte_sync,
   output logic [c_BLOCK_W-1:0]    pt,
   output logic                    rx_empty,
   input  logic                    rx_read,
   output logic                    rx_full,
   output logic                    rx_overrun,
   output logic [$clog2(DEPTH):0]  level
);

   logic [c_SHIFT_W-1:0] r_shift;
   logic [c_IDX_W-1:0]   r_bidx;
   logic                 r_overrun;

   logic                 w_byte_ok;
   logic                 w_block_done;
   logic [c_BLOCK_W-1:0] w_block;
   logic                 w_accept;

   // byte_sync takes priority, so a coincident byte is discarded.
   assign w_byte_ok    = rx_valid && !byte_sync;
   assign w_block_done = w_byte_ok && (r_bidx == c_IDX_LAST);
   assign w_block      = {r_shift, rx_data};

   // Byte assembler: shift bytes 1..15 in at the LSB end, wrap the index on byte 16.
   always_ff @(posedge clk) begin
      if (reset || byte_sync) begin
         r_bidx <= '0;
      end else if (rx_valid) begin
         if (r_bidx == c_IDX_LAST) begin
            r_bidx <= '0;
         end else begin
            r_bidx  <= r_bidx + c_IDX_W'(1);
            r_shift <= {r_shift[c_SHIFT_W-c_BYTE_W-1:0], rx_data};
         end
      end
   end

   // Overrun pulse: a completed block found no room in the queue.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_overrun <= 1'b0;
      end else begin
         r_overrun <= w_block_done && !w_accept;
      end
   end

   assign rx_overrun = r_overrun;

   block_fifo #(
      .WIDTH (c_BLOCK_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .i_push   (w_block_done),
      .i_data   (w_block),
      .i_pop    (rx_read),
      .o_accept (w_accept),
      .o_head   (pt),
      .o_empty  (rx_empty),
      .o_full   (rx_full),
      .o_level  (level)
   );

endmodule : rx_block_buffer
`default_nettype wire

// File: tb/tb_rx_block_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rx_block_buffer
// Description : Scoreboard bench for rx_block_buffer. A byte/queue-level model
//               predicts status; popped blocks are checked by a monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_block_buffer;

   localparam int DEPTH = 4;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic [7:0]   rx_data = 8'h00;
   logic         rx_valid = 1'b0;
   logic         byte_sync = 1'b0;
   logic [127:0] pt;
   logic         rx_empty;
   logic         rx_read = 1'b0;
   logic         rx_full;
   logic         rx_overrun;
   logic [2:0]   level;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   logic [7:0]   bq[$];    // bytes of the block being assembled
   logic [127:0] mq[$];    // blocks the model believes are queued
   logic [127:0] sb_q[$];  // expected pop order for the monitor
   logic         exp_ov = 1'b0;

   rx_block_buffer #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .byte_sync  (byte_sync),
      .pt         (pt),
      .rx_empty   (rx_empty),
      .rx_read    (rx_read),
      .rx_full    (rx_full),
      .rx_overrun (rx_overrun),
      .level      (level)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Model of one clock edge, working on byte lists and a block queue.
   task automatic model_edge(input logic v, input logic [7:0] d, input logic s,
                             input logic r, input logic rs);
      logic [127:0] blk;
      logic         done;
      logic         pop_ok;
      if (rs) begin
         bq.delete();
         mq.delete();
         sb_q.delete();
         exp_ov = 1'b0;
      end else begin
         pop_ok = r && (mq.size() > 0);
         done   = 1'b0;
         blk    = '0;
         if (s) begin
            bq.delete();
         end else if (v) begin
            bq.push_back(d);
            if (bq.size() == 16) begin
               for (int i = 0; i < 16; i++) blk = {blk[119:0], bq[i]};
               bq.delete();
               done = 1'b1;
            end
         end
         if (pop_ok) void'(mq.pop_front());
         exp_ov = 1'b0;
         if (done) begin
            if (mq.size() < DEPTH) begin
               mq.push_back(blk);
               sb_q.push_back(blk);
            end else begin
               exp_ov = 1'b1;
            end
         end
      end
   endtask

   task automatic check_status();
      chk("level", 128'(level), 128'(mq.size()));
      chk("rx_empty", 128'(rx_empty), 128'(mq.size() == 0));
      chk("rx_full", 128'(rx_full), 128'(mq.size() == DEPTH));
      chk("rx_overrun", 128'(rx_overrun), 128'(exp_ov));
      if (mq.size() == 0) chk("pt_when_empty", pt, 128'h0);
   endtask

   // One cycle: drive at the falling edge, model the rising edge, check at the next falling edge.
   task automatic step(input logic v, input logic [7:0] d, input logic s,
                       input logic r, input logic rs);
      rx_valid  = v;
      rx_data   = d;
      byte_sync = s;
      rx_read   = r;
      reset     = rs;
      @(posedge clk);
      model_edge(v, d, s, r, rs);
      @(negedge clk);
      check_status();
   endtask

   task automatic send_block(input logic [7:0] first, input logic read_on_last);
      for (int i = 0; i < 16; i++)
         step(1'b1, first + 8'(i), 1'b0, (i == 15) ? read_on_last : 1'b0, 1'b0);
   endtask

   // Monitor: whenever the reader pops a non-empty FIFO, the head must be the next expected block.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (!reset && rx_read && !rx_empty) begin
            if (sb_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL pop_unexpected: got %h expected no block", pt);
            end else begin
               chk("pop_data", pt, sb_q.pop_front());
            end
         end
      end
   end

   initial begin
      logic [127:0] k55;
      k55 = {16{8'h55}};
      @(negedge clk);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

      // Single block
      send_block(8'h00, 1'b0);
      chk("t1_pt", pt, 128'h000102030405060708090A0B0C0D0E0F);
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

      // Fill to full, then one more block overruns
      for (int b = 1; b <= 5; b++) send_block(8'(b * 16), 1'b0);
      chk("t2_level", 128'(level), 128'd4);

      // 16th byte coincides with a pop while full
      send_block(8'h60, 1'b1);
      for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

      // Resync after a partial block
      for (int i = 0; i < 7; i++) step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 16; i++) step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
      chk("t4_pt", pt, k55);
      chk("t4_level", 128'(level), 128'd1);
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

      // Pops while empty are ignored
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      send_block(8'hC0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

      // Reset in the middle of a block
      for (int i = 0; i < 9; i++) step(1'b1, 8'hE0 + 8'(i), 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'hEE, 1'b0, 1'b1, 1'b1);
      send_block(8'h80, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

      // Randomized traffic: a slow-reader phase then a fast-reader phase
      for (int ph = 0; ph < 2; ph++) begin
         for (int c = 0; c < 1500; c++) begin
            logic v, s, r, rs;
            v  = ($urandom_range(99) < 75);
            s  = ($urandom_range(99) < 2);
            r  = (ph == 0) ? ($urandom_range(99) < 3) : ($urandom_range(99) < 40);
            rs = ($urandom_range(999) < 3);
            step(v, 8'($urandom), s, r, rs);
         end
      end

      // Drain whatever is left
      for (int i = 0; i < 2 * DEPTH; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      chk("sb_drained", 128'(sb_q.size()), 128'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_rx_block_buffer
`default_nettype wire
